// File: rtl/usb_line_pkg.sv
// Line-state and command encodings shared by the usb_interface bus-state blocks.
package usb_line_pkg;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [1:0] CMD_BUS_RESET     = 2'b00;
    localparam logic [1:0] CMD_HOST_RESUME   = 2'b01;
    localparam logic [1:0] CMD_REMOTE_WAKEUP = 2'b10;
    localparam logic [1:0] CMD_RESERVED      = 2'b11;

    localparam int unsigned US_MAX = 65535;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_us_tick.sv
// Microsecond prescaler and 16-bit microsecond counter; in cyc_mode the prescaler
// instead counts raw cycles and saturates, for cycle-timed intervals.
module usb_us_tick #(
    parameter int unsigned CLK_FREQ_MHZ = 60,
    parameter int unsigned PRESC_W      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               cyc_mode,
    output logic               tick,
    output logic [PRESC_W-1:0] presc,
    output logic [15:0]        us_cnt
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ_MHZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_SAT  = {PRESC_W{1'b1}};

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [15:0]        us_q, us_d;

    assign tick   = !cyc_mode && (presc_q == PRESC_LAST);
    assign presc  = presc_q;
    assign us_cnt = us_q;

    always_comb begin
        presc_d = presc_q;
        us_d    = us_q;
        if (clr) begin
            presc_d = '0;
            us_d    = '0;
        end else if (cyc_mode) begin
            if (presc_q != PRESC_SAT) presc_d = presc_q + 1'b1;
        end else if (tick) begin
            presc_d = '0;
            if (us_q != 16'hffff) us_d = us_q + 16'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            us_q    <= '0;
        end else begin
            presc_q <= presc_d;
            us_q    <= us_d;
        end
    end

endmodule

// File: rtl/usb_bus_signal_gen.sv
// Drives timed USB bus states (bus reset, host resume, remote wakeup) onto the
// UTMI transmit side in response to valid/ready commands.
module usb_bus_signal_gen
    import usb_line_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ   = 60,
    parameter int unsigned RESET_US       = 10000,
    parameter int unsigned RESUME_US      = 20000,
    parameter int unsigned WAKEUP_US      = 2000,
    parameter int unsigned WAKEUP_IDLE_US = 5000,
    parameter int unsigned EOP_CYCLES     = 80,
    parameter int unsigned J_CYCLES       = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       abort,
    input  logic [1:0] line_state,
    output logic       tx_oe,
    output logic [1:0] tx_line,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       aborted
);

    if (RESET_US > US_MAX || RESUME_US > US_MAX || WAKEUP_US > US_MAX ||
        WAKEUP_IDLE_US > US_MAX) begin : g_bad_us_param
        $error("usb_bus_signal_gen: microsecond parameter exceeds 16-bit counter");
    end

    localparam int unsigned PRESC_W = $clog2(max3(CLK_FREQ_MHZ, EOP_CYCLES, J_CYCLES) + 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitIdle = 3'd1;
    localparam logic [2:0] StRstSe0   = 3'd2;
    localparam logic [2:0] StResK     = 3'd3;
    localparam logic [2:0] StWakeK    = 3'd4;
    localparam logic [2:0] StEopSe0   = 3'd5;
    localparam logic [2:0] StEopJ     = 3'd6;

    logic [2:0]         state_q, state_d;
    logic               tx_oe_q, tx_oe_d;
    logic [1:0]         tx_line_q, tx_line_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               aborted_q, aborted_d;
    logic               tmr_clr, tmr_cyc_mode, tmr_tick;
    logic [PRESC_W-1:0] tmr_presc;
    logic [15:0]        tmr_us;

    usb_us_tick #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
        .PRESC_W     (PRESC_W)
    ) u_us_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .cyc_mode(tmr_cyc_mode),
        .tick    (tmr_tick),
        .presc   (tmr_presc),
        .us_cnt  (tmr_us)
    );

    // A us-timed state of N us ends on the tick that completes its last microsecond.
    function automatic logic us_last(input logic [15:0] cnt, input logic tk,
                                     input int unsigned n);
        return tk && (cnt == 16'(n - 1));
    endfunction

    assign tmr_cyc_mode = (state_q == StEopSe0) || (state_q == StEopJ);

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_BUS_RESET:     state_d = StRstSe0;
                        CMD_HOST_RESUME:   state_d = StResK;
                        CMD_REMOTE_WAKEUP: state_d = StWaitIdle;
                        default:           err_d   = 1'b1;
                    endcase
                end
            end
            StWaitIdle: begin
                if (line_state == LINE_J && us_last(tmr_us, tmr_tick, WAKEUP_IDLE_US))
                    state_d = StWakeK;
            end
            StRstSe0: if (us_last(tmr_us, tmr_tick, RESET_US)) state_d = StEopJ;
            StResK:   if (us_last(tmr_us, tmr_tick, RESUME_US)) state_d = StEopSe0;
            StWakeK: begin
                if (us_last(tmr_us, tmr_tick, WAKEUP_US)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StEopSe0: if (tmr_presc == PRESC_W'(EOP_CYCLES - 1)) state_d = StEopJ;
            StEopJ: begin
                if (tmr_presc == PRESC_W'(J_CYCLES - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides everything, including completion on the final cycle.
        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    // Counters restart on every state entry; the idle count also restarts on non-J.
    assign tmr_clr = (state_d != state_q) ||
                     (state_q == StWaitIdle && line_state != LINE_J);

    always_comb begin
        tx_oe_d   = 1'b1;
        tx_line_d = LINE_J;
        case (state_d)
            StRstSe0, StEopSe0: tx_line_d = LINE_SE0;
            StResK, StWakeK:    tx_line_d = LINE_K;
            StEopJ:             tx_line_d = LINE_J;
            default:            tx_oe_d   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tx_oe_q   <= 1'b0;
            tx_line_q <= LINE_J;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_oe_q   <= tx_oe_d;
            tx_line_q <= tx_line_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign tx_oe     = tx_oe_q;
    assign tx_line   = tx_line_q;
    assign done      = done_q;
    assign err       = err_q;
    assign aborted   = aborted_q;

endmodule
